// File: rtl/gf2m_pkg.sv
// Shared definitions for the digit-serial GF(2) polynomial multiplier.
package gf2m_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] MODE_LO  = 2'b00;
    localparam logic [1:0] MODE_HI  = 2'b01;
    localparam logic [1:0] MODE_RED = 2'b10;

    // Integer ceil(n / d); d is never zero for legal parameters.
    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gf2m_digit_serial_mul_if.sv
// Operand/result handshake bundle for the GF(2) multiplier.
interface gf2m_digit_serial_mul_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/gf2m_clmul_digit.sv
// Combinational WIDTH x DIGIT carry-less partial product.
module gf2m_clmul_digit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic [WIDTH-1:0]       a_i,
    input  logic [DIGIT-1:0]       d_i,
    output logic [WIDTH+DIGIT-2:0] p_o
);
    localparam int unsigned PPW = WIDTH + DIGIT - 1;

    // XOR together a shifted by each set digit bit.
    always_comb begin
        p_o = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            if (d_i[i]) begin
                p_o = p_o ^ (PPW'(a_i) << i);
            end
        end
    end
endmodule

// File: rtl/gf2m_digit_serial_mul.sv
// Digit-serial carry-less multiplier: low half, high half, or reduced mod POLY.
module gf2m_digit_serial_mul
    import gf2m_pkg::*;
#(
    parameter int unsigned     WIDTH = 8,
    parameter int unsigned     DIGIT = 2,
    parameter logic [WIDTH-1:0] POLY = 'h1B
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gf2m_digit_serial_mul_if.slave  bus,
    output logic                    busy_o
);
    localparam int unsigned PW    = 2 * WIDTH - 1;
    localparam int unsigned PPW   = WIDTH + DIGIT - 1;
    localparam int unsigned NSTEP = ceil_div(WIDTH, DIGIT);
    localparam int unsigned NRED  = ceil_div(WIDTH - 1, DIGIT);
    localparam int unsigned BW    = NSTEP * DIGIT;
    localparam int unsigned CW    = clog2_f(NSTEP + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [BW-1:0]    b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic [PW-1:0]    p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [PPW-1:0]   pp;
    logic [PW-1:0]    p_mul;
    logic [PW-1:0]    p_red;

    // Partial product of a with the current top digit of b.
    gf2m_clmul_digit #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_clmul (
        .a_i (a_q),
        .d_i (b_q[BW-1 -: DIGIT]),
        .p_o (pp)
    );

    // One MUL step: shift the accumulator one digit and add the partial product.
    always_comb begin
        p_mul = (p_q << DIGIT) ^ PW'(pp);
    end

    // One RED step: fold up to DIGIT top positions, highest first, chained.
    always_comb begin
        int k;
        k     = 0;
        p_red = p_q;
        for (int unsigned j = 0; j < DIGIT; j++) begin
            k = int'(PW) - 1 - int'(cnt_q) * int'(DIGIT) - int'(j);
            if (k >= int'(WIDTH)) begin
                if (((p_red >> k) & PW'(1)) != '0) begin
                    p_red = p_red ^ (PW'(1) << k) ^ (PW'(POLY) << (k - int'(WIDTH)));
                end
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        out_y_d = out_y_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = BW'(bus.in_b);
                    mode_d  = (bus.in_mode == 2'b11) ? MODE_LO : bus.in_mode;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                p_d   = p_mul;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NSTEP - 1)) begin
                    cnt_d   = '0;
                    state_d = (mode_q == MODE_RED) ? RED : DONE;
                end
            end
            RED: begin
                p_d   = p_red;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NRED - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture the result once, on entry to DONE, so it holds under backpressure.
        if (state_q != DONE && state_d == DONE) begin
            out_y_d = (mode_q == MODE_HI) ? p_d[PW-1:WIDTH-1] : p_d[WIDTH-1:0];
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_LO;
            p_q         <= '0;
            cnt_q       <= '0;
            out_y_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            out_y_q     <= out_y_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign busy_o        = busy_q;

    // The top digit of the accumulator must be empty before every MUL shift.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == MUL) |-> ((p_q >> (PW - DIGIT)) == '0));

endmodule

// File: doc/gf2m_digit_serial_mul.md
Name: gf2m_digit_serial_mul

Overview:
- Parametrised, sequential carry-less (GF(2) polynomial) multiplier.
- Generalises the fixed-width combinational high-half product block to any WIDTH, a selectable DIGIT size (b bits consumed per cycle), and three result modes: low half, high half, or reduced modulo a field polynomial.
- Sits between operand staging and the crypto/ECC datapath.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 8: operand width W, W ≥ 2.
- DIGIT, 2: bits of b processed per MUL cycle, 1 ≤ DIGIT ≤ W.
- POLY, 8'h1B: low W bits of the monic field polynomial; x^W is implicit. The default is x^8+x^4+x^3+x+1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- in_valid, in, 1: operands and mode presented.
- in_ready, out, 1: block accepts operands.
- in_a, in, WIDTH: multiplicand a.
- in_b, in, WIDTH: multiplier b.
- in_mode, in, 2: 00 = low half, 01 = high half, 10 = reduced mod POLY, 11 = reserved.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts result.
- out_y, out, WIDTH: result.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Constants: NSTEP = ceil(W/DIGIT); NRED = ceil((W-1)/DIGIT); accumulator P is 2W-1 bits.
- Reset (rst_n=0 at a rising edge): state IDLE; P, counters and operand regs cleared. Outputs: in_ready=1, out_valid=0, out_y=0, busy=0. Reset mid-operation aborts the operation; no result is produced.
- Reserved mode: in_mode=11 is latched as 00.
- IDLE: in_ready=1. On in_valid & in_ready:
  - latch a, b (b zero-extended on the MSB side to NSTEP*DIGIT bits) and mode;
  - P <= 0, step counter <= 0;
  - go to MUL.
- MUL: in_ready=0. Each cycle takes the next digit d of b, MSB-first, and computes P <= (P << DIGIT) ^ clmul(a, d), truncated to 2W-1 bits. After the NSTEP-th step:
  - mode 10: go to RED, red counter <= 0;
  - otherwise: go to DONE.
- RED: each cycle folds up to DIGIT highest remaining set-able positions k, from 2W-2 down to W. Folds are top-down within the cycle, chained combinationally.
  - Fold of bit k: if P[k]=1, clear P[k] and XOR POLY << (k-W).
  - After NRED cycles, P[2W-2:W] = 0; go to DONE.
- DONE: out_valid=1. out_y is registered and stable while out_valid & !out_ready.
  - mode 00: out_y = P[W-1:0].
  - mode 01: out_y = P[2W-2:W-1] (coefficients x^(2W-2)..x^(W-1)).
  - mode 10: out_y = P[W-1:0] after reduction.
  - On out_ready: out_valid <= 0, go to IDLE.
- Latency: measured from the accept edge to the first cycle out_valid=1. It is NSTEP cycles (modes 00/01) or NSTEP+NRED cycles (mode 10). Default parameters give 4 and 8.
- Throughput: one result per NSTEP(+NRED)+2 cycles with out_ready held high.
- Input is ignored while in_ready=0, so no input buffering is needed.
- Arithmetic is XOR only; there are no carries. Shift overflow beyond bit 2W-2 cannot occur; an assertion checks this.

Decomposition:
- Shared package gf2m_pkg holds:
  - mode encoding constants MODE_LO, MODE_HI, MODE_RED;
  - state enum IDLE/MUL/RED/DONE;
  - functions clog/ceil-div for NSTEP/NRED.
- One sub-module: gf2m_clmul_digit. It is combinational, W x DIGIT carry-less partial product, output W+DIGIT-1 bits, reused per MUL cycle.
- The reduction fold chain stays inline in the top level.

Test Plan:
- Default params, a=0x57, b=0x83, mode 10, out_ready=1 → out_y=0xC1, out_valid 8 cycles after accept, busy high throughout.
- Same operands, mode 00 → out_y=0x79; mode 01 → out_y=0x56 (full product 0x2B79); latency 4 cycles.
- a=0x02, b=0x80, mode 10 → 0x1B. Then a=0xFF, b=0x00, any mode → 0x00. Then a=0x01, b=0xA5, mode 00 → 0xA5.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_y and out_valid held, in_ready=0; raising out_ready returns to IDLE the next cycle.
- Reset mid-MUL: rst_n=0 during the 2nd MUL cycle → next cycle in_ready=1, out_valid=0, out_y=0, busy=0. A new operation afterwards gives a correct result.
- WIDTH=7, DIGIT=3, POLY=7'h03 (x^7+x+1), random 500 vectors, all modes, against a reference model. Covers the partial first digit (NSTEP=3, NRED=2); in_mode=11 must match mode 00.
